// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ctrl_pkg;

    // Controller state codes; the debug port exposes these values directly.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    // Supported RV32I major opcodes (IR[6:0]).
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Instruction classes produced by opcode_class.
    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_I      = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;
    localparam logic [2:0] CLS_JALR   = 3'd6;

    // Datapath mux selects.
    localparam logic       IOD_PC       = 1'b0;
    localparam logic       IOD_ALUOUT   = 1'b1;
    localparam logic [1:0] MTR_ALUOUT   = 2'b00;
    localparam logic [1:0] MTR_MDR      = 2'b01;
    localparam logic [1:0] MTR_PC       = 2'b10;
    localparam logic [1:0] SRCA_RS1     = 2'b00;
    localparam logic [1:0] SRCA_PC      = 2'b01;
    localparam logic [1:0] SRCA_OLDPC   = 2'b10;
    localparam logic [1:0] SRCB_RS2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_CMP    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic       PCSRC_ALU    = 1'b0;
    localparam logic       PCSRC_ALUOUT = 1'b1;

endpackage

// File: rtl/opcode_class.sv
// Maps a 7-bit RV32I opcode to an instruction class plus an illegal flag.
// Latency: purely combinational.
// Backpressure: none.
module opcode_class
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] op_class,
    output logic       illegal
);

    // Classify the opcode; anything outside the supported set is illegal.
    always_comb begin
        op_class = CLS_R;
        illegal  = 1'b0;
        case (opcode)
            OP_R:      op_class = CLS_R;
            OP_I:      op_class = CLS_I;
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  op_class = CLS_STORE;
            OP_BRANCH: op_class = CLS_BRANCH;
            OP_JAL:    op_class = CLS_JAL;
            OP_JALR:   op_class = CLS_JALR;
            default:   illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing one RV32I instruction through fetch/decode/exec/mem/wb.
// Latency: 3 (branch/jal/jalr), 4 (R/I/store), 5 (load) cycles plus memory waits.
// Backpressure: holds in FETCH/MEM while mem_ready is low; illegal opcode parks in TRAP.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             taken,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_src,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    logic [2:0]       state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [6:0]       cls_opcode;
    logic [2:0]       cls;
    logic             cls_illegal;

    // DECODE judges the live IR opcode; every later state works from the latched copy.
    assign cls_opcode = (state_q == ST_DECODE) ? opcode : op_q;

    opcode_class u_opcode_class (
        .opcode   (cls_opcode),
        .op_class (cls),
        .illegal  (cls_illegal)
    );

    // Next-state, opcode latch and retire counting.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                op_d    = opcode;
                state_d = cls_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_R, CLS_I:        state_d = ST_WB;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_FETCH;
                endcase
            end
            ST_MEM:    if (mem_ready) state_d = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
        // An instruction retires whenever we re-enter FETCH from anywhere but IDLE.
        if (state_d == ST_FETCH && state_q != ST_FETCH && state_q != ST_IDLE) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State, opcode latch and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 7'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    // Output decode from state and latched class; pc_write also follows mem_ready/taken.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = IOD_PC;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = MTR_ALUOUT;
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        halted     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_R: alu_op = ALUOP_FUNCT;
                    CLS_I: begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALUOP_FUNCT;
                    end
                    CLS_LOAD, CLS_STORE: alu_src_b = SRCB_IMM;
                    CLS_BRANCH: begin
                        alu_op   = ALUOP_CMP;
                        pc_src   = PCSRC_ALUOUT;
                        pc_write = taken;
                    end
                    CLS_JAL: begin
                        reg_write  = 1'b1;
                        mem_to_reg = MTR_PC;
                        pc_src     = PCSRC_ALUOUT;
                        pc_write   = 1'b1;
                    end
                    CLS_JALR: begin
                        // rs1 is sampled before the edge, so rd==rs1 still jumps via the old value.
                        alu_src_b  = SRCB_IMM;
                        reg_write  = 1'b1;
                        mem_to_reg = MTR_PC;
                        pc_write   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                i_or_d    = IOD_ALUOUT;
                mem_read  = (cls == CLS_LOAD);
                mem_write = (cls == CLS_STORE);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == CLS_LOAD) ? MTR_MDR : MTR_ALUOUT;
            end
            ST_TRAP:  halted = 1'b1;
            default: ;
        endcase
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule
